// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch, decode, operand
// access and execute, with mem_ready handshakes, a wait timeout, halt/resume and a fault trap.
module cpu_ctrl_seq #(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                is_zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                ir_load,
  output logic                pc_en,
  output logic                pc_load,
  output logic                jmp,
  output logic                halt,
  output logic                fault,
  output logic                accumulator_load,
  output logic                accumulator_control,
  output logic                alu_sub,
  output logic                memIns_en,
  output logic                memDa_en,
  output logic                memDa_we
);

  typedef enum logic [3:0] {
    S_IDLE, S_IFETCH, S_DECODE, S_SKIP, S_JUMP, S_OPFETCH, S_EXEC, S_HALT, S_FAULT
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_HLT = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int               LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op;
  logic             illegal;
  logic             timed_out;

  assign op = opcode[2:0];

  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign illegal = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign illegal = 1'b0;
    end
  endgenerate

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only survives while a memory phase keeps waiting, so every
  // entry into IFETCH or OPFETCH starts from zero.
  always_comb begin
    state_d             = state_q;
    cnt_d               = '0;
    ir_load             = 1'b0;
    pc_en               = 1'b0;
    pc_load             = 1'b0;
    jmp                 = 1'b0;
    halt                = 1'b0;
    fault               = 1'b0;
    accumulator_load    = 1'b0;
    accumulator_control = 1'b0;
    alu_sub             = 1'b0;
    memIns_en           = 1'b0;
    memDa_en            = 1'b0;
    memDa_we            = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_IFETCH;

      S_IFETCH: begin
        memIns_en = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (illegal) begin
          state_d = S_FAULT;
        end else begin
          pc_en = 1'b1;
          case (op)
            OP_NOP: state_d = S_IFETCH;
            OP_SKZ: state_d = is_zero ? S_SKIP : S_IFETCH;
            OP_JMP: state_d = S_JUMP;
            OP_HLT: state_d = S_HALT;
            default: state_d = S_OPFETCH;
          endcase
        end
      end

      S_SKIP: begin
        pc_en   = 1'b1;
        state_d = S_IFETCH;
      end

      S_JUMP: begin
        pc_load = 1'b1;
        jmp     = 1'b1;
        state_d = S_IFETCH;
      end

      S_OPFETCH: begin
        memDa_en = 1'b1;
        memDa_we = (op == OP_STO);
        if (mem_ready) begin
          state_d = (op == OP_STO) ? S_IFETCH : S_EXEC;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EXEC: begin
        accumulator_load    = 1'b1;
        accumulator_control = (op == OP_ADD) || (op == OP_SUB);
        alu_sub             = (op == OP_SUB);
        state_d             = S_IFETCH;
      end

      S_HALT: begin
        halt = 1'b1;
        if (resume) state_d = S_IFETCH;
      end

      S_FAULT: begin
        halt  = 1'b1;
        fault = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: per-instruction expected output traces
// built from the instruction timing rules, driven with randomized waits and decoy inputs.
module tb_cpu_ctrl_seq;

  localparam int OPW = 4;
  localparam int TO  = 15;

  // Output vector bit positions, MSB first
  localparam logic [11:0] IR = 12'h800, PC = 12'h400, PCL = 12'h200, JP = 12'h100;
  localparam logic [11:0] HL = 12'h080, FL = 12'h040, AL = 12'h020, AC = 12'h010;
  localparam logic [11:0] AS = 12'h008, MI = 12'h004, MD = 12'h002, MW = 12'h001;
  localparam logic [11:0] ZZ = 12'h000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [OPW-1:0] opcode = '0;
  logic           is_zero = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic ir_load, pc_en, pc_load, jmp, halt, fault;
  logic accumulator_load, accumulator_control, alu_sub, memIns_en, memDa_en, memDa_we;
  logic [11:0] outv;

  int  nChecks = 0;
  int  nPass   = 0;
  bit  holdResume = 1'b0;

  cpu_ctrl_seq #(.OPCODE_W(OPW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .mem_ready(mem_ready), .resume(resume),
    .ir_load(ir_load), .pc_en(pc_en), .pc_load(pc_load), .jmp(jmp),
    .halt(halt), .fault(fault), .accumulator_load(accumulator_load),
    .accumulator_control(accumulator_control), .alu_sub(alu_sub),
    .memIns_en(memIns_en), .memDa_en(memDa_en), .memDa_we(memDa_we)
  );

  assign outv = {ir_load, pc_en, pc_load, jmp, halt, fault, accumulator_load,
                 accumulator_control, alu_sub, memIns_en, memDa_en, memDa_we};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic rbit();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic rres();
    return holdResume | rbit();
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // One clock cycle: drive inputs just after the edge, check outputs mid-cycle.
  task automatic applyStimulus(input logic [OPW-1:0] op, input logic rdy, input logic res,
                               input logic iz, input logic [11:0] exp, input string tag);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    resume    = res;
    is_zero   = iz;
    #3;
    checkOutput(tag, outv, exp);
  endtask

  // Called mid-cycle: outputs must vanish at once, then one IDLE cycle follows release.
  task automatic applyReset();
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", outv, ZZ);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mem_ready  = rbit();
    resume     = rbit();
    holdResume = 1'b0;
    #3;
    checkOutput("idle", outv, ZZ);
  endtask

  // Expected trace of one instruction, starting at IFETCH entry.
  task automatic execInstr(input logic [OPW-1:0] op, input logic iz,
                           input int iw, input int dw, input int hw);
    logic [2:0]  op3;
    logic        legal;
    logic [11:0] mexp;
    op3   = op[2:0];
    legal = (op[OPW-1:3] == '0);
    for (int i = 0; i < iw; i++) applyStimulus(op, 1'b0, rres(), rbit(), MI, "ifetch_wait");
    applyStimulus(op, 1'b1, rres(), rbit(), MI | IR, "ifetch_ready");
    applyStimulus(op, rbit(), rres(), iz, legal ? PC : ZZ, "decode");
    if (!legal) begin
      repeat (3) applyStimulus(op, rbit(), 1'b1, rbit(), HL | FL, "fault_hold");
      return;
    end
    case (op3)
      3'd0: ;
      3'd1: if (iz) applyStimulus(op, rbit(), rres(), rbit(), PC, "skip");
      3'd7: applyStimulus(op, rbit(), rres(), rbit(), PCL | JP, "jump");
      3'd4: begin
        for (int i = 0; i < hw; i++) applyStimulus(op, rbit(), 1'b0, rbit(), HL, "halt_hold");
        applyStimulus(op, rbit(), 1'b1, rbit(), HL, "halt_resume");
      end
      default: begin
        mexp = (op3 == 3'd6) ? (MD | MW) : MD;
        for (int i = 0; i < dw; i++) applyStimulus(op, 1'b0, rres(), rbit(), mexp, "opfetch_wait");
        applyStimulus(op, 1'b1, rres(), rbit(), mexp, "opfetch_ready");
        if (op3 != 3'd6)
          applyStimulus(op, rbit(), rres(), rbit(),
                        AL | ((op3 != 3'd5) ? AC : ZZ) | ((op3 == 3'd3) ? AS : ZZ), "exec");
      end
    endcase
  endtask

  // TO low cycles in a memory phase trap into FAULT, which resume cannot leave.
  task automatic timeoutCase(input bit dataPhase);
    logic [OPW-1:0] op;
    op = 4'b0101;
    if (dataPhase) begin
      applyStimulus(op, 1'b1, 1'b0, 1'b0, MI | IR, "to_ifetch");
      applyStimulus(op, 1'b0, 1'b0, 1'b0, PC, "to_decode");
    end
    for (int i = 0; i < TO; i++)
      applyStimulus(op, 1'b0, 1'b0, 1'b0, dataPhase ? MD : MI, "to_wait");
    applyStimulus(op, 1'b1, 1'b1, 1'b0, HL | FL, "to_fault");
    applyStimulus(op, 1'b1, 1'b1, 1'b0, HL | FL, "to_fault_hold");
    applyReset();
  endtask

  initial begin
    logic [OPW-1:0] rop;
    applyReset();

    repeat (4) execInstr(4'b0000, 1'b0, 0, 0, 0);
    execInstr(4'b0101, 1'b0, 0, 3, 0);
    execInstr(4'b0010, 1'b0, 0, 0, 0);
    execInstr(4'b0011, 1'b0, 0, 0, 0);
    execInstr(4'b0001, 1'b1, 0, 0, 0);
    execInstr(4'b0001, 1'b0, 0, 0, 0);
    execInstr(4'b0110, 1'b0, 0, 2, 0);
    execInstr(4'b0111, 1'b0, 0, 0, 0);
    execInstr(4'b0100, 1'b0, 0, 0, 10);
    holdResume = 1'b1;
    execInstr(4'b0100, 1'b0, 0, 0, 0);
    execInstr(4'b0100, 1'b0, 0, 0, 0);
    holdResume = 1'b0;

    execInstr(4'b0000, 1'b0, TO - 1, 0, 0);
    execInstr(4'b0101, 1'b0, 0, TO - 1, 0);
    execInstr(4'b0110, 1'b0, 2, TO - 1, 0);

    applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, MI | IR, "sto_ifetch");
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, PC, "sto_decode");
    applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, MD | MW, "sto_opfetch");
    applyReset();

    execInstr(4'b1000, 1'b0, 1, 0, 0);
    applyReset();
    timeoutCase(1'b0);
    timeoutCase(1'b1);

    for (int n = 0; n < 150; n++) begin
      rop = OPW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) rop[OPW-1] = 1'b1;
      execInstr(rop, rbit(), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      if (rop[OPW-1]) applyReset();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
